// File: rtl/uart_tx_engine.sv
// UART transmitter: start bit, DATA_WIDTH data bits LSB first, optional parity, 1..2 stop bits.
// The character and the baud divisor are captured at the handshake, so later input changes only affect the next frame.
module uart_tx_engine #(
    parameter int DATA_WIDTH = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1,
    parameter int DIV_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    input  logic [DIV_WIDTH-1:0]  baud_div,
    output logic                  tx,
    output logic                  busy,
    output logic                  frame_done
);
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    localparam int                   CNT_W     = 4;
    localparam logic [CNT_W-1:0]     LAST_DATA = CNT_W'(DATA_WIDTH - 1);
    localparam logic [CNT_W-1:0]     LAST_STOP = CNT_W'(STOP_BITS - 1);
    localparam logic [CNT_W-1:0]     CNT_ONE   = CNT_W'(1);
    localparam logic [DIV_WIDTH-1:0] DIV_ONE   = DIV_WIDTH'(1);

    state_t                state;
    logic [DATA_WIDTH-1:0] shreg;
    logic                  par_q;
    logic [DIV_WIDTH-1:0]  reload_q;
    logic [DIV_WIDTH-1:0]  baud_cnt;
    logic [CNT_W-1:0]      bit_cnt;
    logic [DIV_WIDTH-1:0]  reload_d;
    logic                  accept;
    logic                  bit_end;

    // Counter runs reload..0, so a divisor of 0 or 1 both give one-clock bits.
    assign reload_d = (baud_div <= DIV_ONE) ? '0 : baud_div - DIV_ONE;
    assign accept   = tx_valid & tx_ready;
    assign bit_end  = (baud_cnt == '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            tx         <= 1'b1;
            busy       <= 1'b0;
            tx_ready   <= 1'b0;
            frame_done <= 1'b0;
            shreg      <= '0;
            par_q      <= 1'b0;
            reload_q   <= '0;
            baud_cnt   <= '0;
            bit_cnt    <= '0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    tx   <= 1'b1;
                    busy <= 1'b0;
                    if (accept) begin
                        shreg    <= tx_data;
                        par_q    <= (^tx_data) ^ (PARITY_ODD != 0);
                        reload_q <= reload_d;
                        baud_cnt <= reload_d;
                        bit_cnt  <= '0;
                        tx       <= 1'b0;
                        busy     <= 1'b1;
                        tx_ready <= 1'b0;
                        state    <= START;
                    end else begin
                        tx_ready <= 1'b1;
                    end
                end

                START: begin
                    if (bit_end) begin
                        baud_cnt <= reload_q;
                        bit_cnt  <= '0;
                        tx       <= shreg[0];
                        state    <= DATA;
                    end else begin
                        baud_cnt <= baud_cnt - DIV_ONE;
                    end
                end

                DATA: begin
                    if (bit_end) begin
                        baud_cnt <= reload_q;
                        if (bit_cnt == LAST_DATA) begin
                            bit_cnt <= '0;
                            if (PARITY_EN != 0) begin
                                tx    <= par_q;
                                state <= PARITY;
                            end else begin
                                tx         <= 1'b1;
                                frame_done <= (reload_q == '0) && (LAST_STOP == '0);
                                state      <= STOP;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + CNT_ONE;
                            shreg   <= shreg >> 1;
                            tx      <= shreg[1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt - DIV_ONE;
                    end
                end

                PARITY: begin
                    if (bit_end) begin
                        baud_cnt   <= reload_q;
                        bit_cnt    <= '0;
                        tx         <= 1'b1;
                        frame_done <= (reload_q == '0) && (LAST_STOP == '0);
                        state      <= STOP;
                    end else begin
                        baud_cnt <= baud_cnt - DIV_ONE;
                    end
                end

                STOP: begin
                    // frame_done is registered, so it is raised one edge ahead of the final stop cycle.
                    if (bit_end) begin
                        if (bit_cnt == LAST_STOP) begin
                            busy     <= 1'b0;
                            tx_ready <= 1'b1;
                            state    <= IDLE;
                        end else begin
                            bit_cnt    <= bit_cnt + CNT_ONE;
                            baud_cnt   <= reload_q;
                            frame_done <= (reload_q == '0) && ((bit_cnt + CNT_ONE) == LAST_STOP);
                        end
                    end else begin
                        baud_cnt   <= baud_cnt - DIV_ONE;
                        frame_done <= (baud_cnt == DIV_ONE) && (bit_cnt == LAST_STOP);
                    end
                end

                default: begin
                    tx       <= 1'b1;
                    busy     <= 1'b0;
                    tx_ready <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_engine.sv
// Scoreboarded bench for uart_tx_engine: four configurations, each frame predicted as a list of bit levels.
module tb_uart_tx_engine;
    localparam int DW [4] = '{8, 7, 7, 8};
    localparam int PE [4] = '{0, 1, 1, 0};
    localparam int PO [4] = '{0, 0, 1, 0};
    localparam int SB [4] = '{1, 1, 1, 2};
    localparam int TMO = 4000;

    typedef struct {
        logic [7:0]  data;
        logic [15:0] div;
        int          acc;
    } frame_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  vld = '0;
    logic [7:0]  d  [4];
    logic [15:0] dv [4];
    wire  [3:0]  rdy_w, tx_w, busy_w, done_w;
    int          cyc = 0;
    int          n_chk = 0;
    int          n_pass = 0;
    frame_t      sbq [4][$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_tx_engine #(.DATA_WIDTH(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1), .DIV_WIDTH(16)) u0 (
        .clk(clk), .rst(rst), .tx_data(d[0]), .tx_valid(vld[0]), .tx_ready(rdy_w[0]),
        .baud_div(dv[0]), .tx(tx_w[0]), .busy(busy_w[0]), .frame_done(done_w[0]));
    uart_tx_engine #(.DATA_WIDTH(7), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1), .DIV_WIDTH(16)) u1 (
        .clk(clk), .rst(rst), .tx_data(d[1][6:0]), .tx_valid(vld[1]), .tx_ready(rdy_w[1]),
        .baud_div(dv[1]), .tx(tx_w[1]), .busy(busy_w[1]), .frame_done(done_w[1]));
    uart_tx_engine #(.DATA_WIDTH(7), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1), .DIV_WIDTH(16)) u2 (
        .clk(clk), .rst(rst), .tx_data(d[2][6:0]), .tx_valid(vld[2]), .tx_ready(rdy_w[2]),
        .baud_div(dv[2]), .tx(tx_w[2]), .busy(busy_w[2]), .frame_done(done_w[2]));
    uart_tx_engine #(.DATA_WIDTH(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2), .DIV_WIDTH(16)) u3 (
        .clk(clk), .rst(rst), .tx_data(d[3]), .tx_valid(vld[3]), .tx_ready(rdy_w[3]),
        .baud_div(dv[3]), .tx(tx_w[3]), .busy(busy_w[3]), .frame_done(done_w[3]));

    function automatic void check(input bit ok, input string name, input int act, input int req);
        n_chk++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
    endfunction

    // Reference frame: line levels, one entry per bit period.
    function automatic int build(input int g, input logic [7:0] data, output logic eb [16]);
        int nb = 0;
        int ones = 0;
        for (int i = 0; i < 16; i++) eb[i] = 1'b1;
        eb[nb] = 1'b0; nb++;
        for (int i = 0; i < DW[g]; i++) begin
            eb[nb] = data[i]; nb++;
            ones += int'(data[i]);
        end
        if (PE[g] != 0) begin
            eb[nb] = ((ones + PO[g]) % 2) == 1; nb++;
        end
        for (int i = 0; i < SB[g]; i++) begin
            eb[nb] = 1'b1; nb++;
        end
        return nb;
    endfunction

    for (genvar g = 0; g < 4; g++) begin : g_sb
        always @(posedge clk)
            if (rst && vld[g] && rdy_w[g]) sbq[g].push_back('{data: d[g], div: dv[g], acc: cyc});

        initial begin : mon
            frame_t f;
            logic   eb [16];
            int     nb, n, total, bad, bad_at, dbad, t;
            bit     aborted;
            forever begin
                @(negedge clk);
                if (rst && busy_w[g]) begin
                    if (sbq[g].size() == 0) begin
                        check(1'b0, $sformatf("spurious_frame[%0d]", g), 1, 0);
                        t = 0;
                        while (busy_w[g] && t < TMO) begin @(negedge clk); t++; end
                    end else begin
                        f = sbq[g].pop_front();
                        check(cyc == f.acc + 1, $sformatf("latency[%0d]", g), cyc - f.acc, 1);
                        nb = build(g, f.data, eb);
                        n = (f.div <= 16'd1) ? 1 : int'(f.div);
                        total = nb * n;
                        bad = 0; bad_at = -1; dbad = 0; aborted = 1'b0;
                        for (int c = 0; c < total; c++) begin
                            if (c > 0) @(negedge clk);
                            if (!rst) begin aborted = 1'b1; break; end
                            if (tx_w[g] !== eb[c / n] || busy_w[g] !== 1'b1 || rdy_w[g] !== 1'b0) begin
                                if (bad == 0) bad_at = c;
                                bad++;
                            end
                            if (done_w[g] !== (c == total - 1)) dbad++;
                        end
                        if (!aborted) begin
                            check(bad == 0, $sformatf("frame_bits[%0d] data=%02h div=%0d first_bad_cycle", g, f.data, f.div), bad_at, -1);
                            check(dbad == 0, $sformatf("frame_done_pos[%0d] bad_cycles", g), dbad, 0);
                            @(negedge clk);
                            if (rst)
                                check(rdy_w[g] === 1'b1 && busy_w[g] === 1'b0 && tx_w[g] === 1'b1,
                                      $sformatf("idle_after[%0d] {rdy,busy,tx}", g),
                                      int'({rdy_w[g], busy_w[g], tx_w[g]}), 5);
                        end
                    end
                end
            end
        end
    end

    task automatic send(input int g, input logic [7:0] data, input logic [15:0] div, input bit hold);
        int t = 0;
        @(negedge clk);
        d[g] = data; dv[g] = div; vld[g] = 1'b1;
        while (rdy_w[g] !== 1'b1 && t < TMO) begin @(negedge clk); t++; end
        if (t >= TMO) begin
            check(1'b0, $sformatf("ready_timeout[%0d]", g), 0, 1);
            vld[g] = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        // Scramble inputs right after the handshake; the frame must not notice.
        d[g] = 8'($urandom);
        dv[g] = 16'($urandom);
        if (!hold) vld[g] = 1'b0;
    endtask

    task automatic wait_idle(input int g);
        int t = 0;
        while (!(rdy_w[g] === 1'b1 && busy_w[g] === 1'b0 && sbq[g].size() == 0) && t < TMO) begin
            @(negedge clk); t++;
        end
        if (t >= TMO) check(1'b0, $sformatf("idle_timeout[%0d]", g), 0, 1);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, required finish before 5ms");
        $fatal(1);
    end

    initial begin
        int t, fd, sb;
        for (int g = 0; g < 4; g++) begin d[g] = '0; dv[g] = 16'd4; end
        #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        for (int g = 0; g < 4; g++)
            check(tx_w[g] === 1'b1 && busy_w[g] === 1'b0 && rdy_w[g] === 1'b0 && done_w[g] === 1'b0,
                  $sformatf("reset_state[%0d] {tx,busy,rdy,done}", g),
                  int'({tx_w[g], busy_w[g], rdy_w[g], done_w[g]}), 8);
        rst = 1'b1;
        #1 check(rdy_w == 4'h0, "ready_before_edge", int'(rdy_w), 0);
        @(negedge clk);
        check(rdy_w == 4'hF, "ready_first_edge", int'(rdy_w), 15);

        // A5 at divisor 4 on the default configuration
        send(0, 8'hA5, 16'd4, 1'b0);
        wait_idle(0);

        // 7-bit parity, even then odd
        send(1, 8'h03, 16'd3, 1'b0);
        send(2, 8'h03, 16'd3, 1'b0);
        wait_idle(1);
        wait_idle(2);

        // Two stop bits at divisor 0 and 1, back to back
        send(3, 8'hFF, 16'd0, 1'b0);
        wait_idle(3);
        send(3, 8'h00, 16'd1, 1'b1);
        send(3, 8'h81, 16'd0, 1'b0);
        wait_idle(3);

        // Valid held through a frame, new data presented during the third data bit
        send(0, 8'hC3, 16'd4, 1'b1);
        repeat (13) @(negedge clk);
        d[0] = 8'h3C; dv[0] = 16'd4;
        t = 0;
        while (done_w[0] !== 1'b1 && t < TMO) begin @(negedge clk); t++; end
        fd = cyc;
        t = 0;
        do begin @(negedge clk); t++; end while (busy_w[0] !== 1'b1 && t < TMO);
        sb = cyc;
        vld[0] = 1'b0;
        check(sb - fd == 2, "b2b_idle_gap", sb - fd - 1, 1);
        wait_idle(0);

        // Divisor raised mid-frame applies only to the next frame
        send(0, 8'h96, 16'd4, 1'b0);
        repeat (10) @(negedge clk);
        dv[0] = 16'd8;
        wait_idle(0);
        send(0, 8'h69, 16'd8, 1'b0);
        wait_idle(0);

        // Reset in the middle of the data bits
        send(0, 8'h33, 16'd4, 1'b0);
        repeat (8) @(posedge clk);
        #3 rst = 1'b0;
        #1 check(tx_w[0] === 1'b1 && busy_w[0] === 1'b0, "async_reset {tx,busy}",
                 int'({tx_w[0], busy_w[0]}), 2);
        check(rdy_w[0] === 1'b0 && done_w[0] === 1'b0, "async_reset {rdy,done}",
              int'({rdy_w[0], done_w[0]}), 0);
        repeat (3) @(negedge clk);
        for (int g = 0; g < 4; g++) sbq[g].delete();
        rst = 1'b1;
        @(negedge clk);
        check(rdy_w[0] === 1'b1, "ready_after_reset", int'(rdy_w[0]), 1);
        send(0, 8'h5A, 16'd4, 1'b0);
        wait_idle(0);

        // Random frames on every configuration, some back to back
        for (int g = 0; g < 4; g++) begin
            for (int i = 0; i < 16; i++) begin
                bit hold;
                hold = (i != 15) && ($urandom_range(0, 3) == 0);
                send(g, 8'($urandom), 16'($urandom_range(0, 6)), hold);
                if (!hold) repeat ($urandom_range(0, 3)) @(negedge clk);
            end
            wait_idle(g);
        end

        repeat (5) @(negedge clk);
        for (int g = 0; g < 4; g++)
            check(sbq[g].size() == 0, $sformatf("sb_empty[%0d]", g), sbq[g].size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
